// File: rtl/multiword_add_seq.sv
// multiword_add_seq
//   Adds two wide operands (WORDS slices of SIZE bits each) one slice per
//   clock through an external combinational SIZE-bit adder that computes
//   {add_cout, add_sum} = add_a + add_b + add_cin.
//   The carry is chained between slices in a local register. The result is
//   assembled LSB slice first by shifting right.
//
// Ports
//   clk, rst_n           clock and asynchronous active-low reset
//   in_valid / in_ready  operand handshake (op_a, op_b, cin)
//   add_a, add_b,        slice operands and carry driven to the adder
//   add_cin              (forced to 0 outside RUN)
//   add_sum, add_cout    adder response, captured on every RUN edge
//   out_valid/out_ready  result handshake (result, cout)
module multiword_add_seq #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE*WORDS-1:0] op_a,
  input  logic [SIZE*WORDS-1:0] op_b,
  input  logic                  cin,
  output logic [SIZE-1:0]       add_a,
  output logic [SIZE-1:0]       add_b,
  output logic                  add_cin,
  input  logic [SIZE-1:0]       add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE*WORDS-1:0] result,
  output logic                  cout
);

  localparam int W  = SIZE * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           last_slice;

  assign accept     = in_valid && (state == IDLE);
  assign last_slice = (state == RUN) && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        // Only registers feed the adder, so the critical path is the adder.
        add_a   = a_sh[SIZE-1:0];
        add_b   = b_sh[SIZE-1:0];
        add_cin = carry;
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the datapath registers are few and visible on ports, so they are
  // all reset; an abort mid-operation must leave zeroed outputs behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh   <= op_a;
            b_sh   <= op_b;
            carry  <= cin;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
          end
        end
        RUN: begin
          // New slice enters at the top; after WORDS shifts slice 0 sits at
          // the bottom. Written as shifts so WORDS=1 needs no special case.
          result <= (result >> SIZE) | (W'(add_sum) << (W - SIZE));
          carry  <= add_cout;
          a_sh   <= a_sh >> SIZE;
          b_sh   <= b_sh >> SIZE;
          cnt    <= cnt + CW'(1);
          if (last_slice) cout <= add_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Testbench for multiword_add_seq (SIZE=4, WORDS=4).
// A behavioural 4-bit adder is attached to the adder port. Expected results
// come from plain wide addition of the accepted operands and are queued when
// an operand handshake is seen. A monitor compares them whenever out_valid is
// high and pops them on the result handshake.
module tb_multiword_add_seq;

  localparam int SIZE  = 4;
  localparam int WORDS = 4;
  localparam int W     = SIZE * WORDS;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             cin;
  logic [SIZE-1:0]  add_a;
  logic [SIZE-1:0]  add_b;
  logic             add_cin;
  logic [SIZE-1:0]  add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic             cout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W:0] sb_q[$];       // expected {cout, result}
  int         acc_cyc_q[$];  // accepting edge per queued operation
  int         acc_hist[$];   // accepting edges, for throughput checks
  bit         prev_ov = 1'b0;
  bit         rand_bp = 1'b0;

  multiword_add_seq #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout)
  );

  // Attached combinational slice adder.
  logic [SIZE:0] add_res;
  assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {{SIZE{1'b0}}, add_cin};
  assign add_sum  = add_res[SIZE-1:0];
  assign add_cout = add_res[SIZE];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Operand-side observer: model the whole operation as one wide addition.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb_q.push_back({1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin});
      acc_cyc_q.push_back(cyc + 1);
      acc_hist.push_back(cyc + 1);
    end
  end

  // Result-side monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_while_done", {31'b0, in_ready}, 32'd0);
        if (!prev_ov) begin
          if (acc_cyc_q.size() == 0) begin
            check("latency_no_accept", 32'd1, 32'd0);
          end else begin
            check("latency", cyc - acc_cyc_q[0], WORDS);
            void'(acc_cyc_q.pop_front());
          end
        end
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          check("result", {16'b0, result}, {16'b0, sb_q[0][W-1:0]});
          check("cout", {31'b0, cout}, {31'b0, sb_q[0][W]});
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  // Random backpressure during the random phase.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Present operands until accepted; returns one cycle into RUN (slice 0).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bit ok;
    ok       = 1'b0;
    op_a     = a;
    op_b     = b;
    cin      = c;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd1, 32'd0);
  endtask

  // Wait until all queued results are consumed and the block is idle.
  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && !out_valid && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},  {31'b0, in_ready},  32'd1);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_result"},    {16'b0, result},    32'd0);
    check({tag, "_cout"},      {31'b0, cout},      32'd0);
    check({tag, "_add_a"},     {28'b0, add_a},     32'd0);
    check({tag, "_add_b"},     {28'b0, add_b},     32'd0);
    check({tag, "_add_cin"},   {31'b0, add_cin},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           run_len;
    int           max_run;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);

    // Reset asserted mid-clock takes effect immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic: slices of op_a appear LSB first on the adder port.
    a = 16'h1234;
    send(a, 16'h4321, 1'b0);
    for (int k = 0; k < WORDS; k++) begin
      @(negedge clk);
      check($sformatf("basic_add_a_%0d", k), {28'b0, add_a}, {28'b0, a[k*SIZE +: SIZE]});
    end
    drain();

    // Carry ripple through every slice.
    send(16'hFFFF, 16'h0000, 1'b1);
    for (int k = 0; k < WORDS; k++) begin
      @(negedge clk);
      check($sformatf("ripple_add_cin_%0d", k), {31'b0, add_cin}, 32'd1);
    end
    drain();

    // Backpressure: result held, concurrent operands ignored.
    out_ready = 1'b0;
    send(16'h00FF, 16'h0001, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      op_a     = 16'($urandom);
      op_b     = 16'($urandom);
      @(negedge clk);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_result", {16'b0, result}, 32'h0100);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    drain();

    // Reset during RUN cycle 2 discards the operation.
    send(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrun_reset");
    sb_q.delete();
    acc_cyc_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(16'h0001, 16'h0001, 1'b1);
    drain();

    // Back-to-back with in_valid held high.
    acc_hist.delete();
    out_ready = 1'b1;
    op_a      = 16'h8000;
    op_b      = 16'h8000;
    cin       = 1'b0;
    in_valid  = 1'b1;
    run_len   = 0;
    max_run   = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      run_len = out_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    check("b2b_out_valid_pulse", max_run, 32'd1);
    check("b2b_accept_count_ge3", {31'b0, acc_hist.size() >= 3}, 32'd1);
    for (int i = 1; i < acc_hist.size(); i++)
      check($sformatf("b2b_interval_%0d", i), acc_hist[i] - acc_hist[i-1], WORDS + 2);

    // Random operands with random backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
